// File: rtl/wave_seq_pkg.sv
// rtl/wave_seq_pkg.sv - shared types and default widths for the timed-waveform source
package wave_seq_pkg;

    localparam int DEF_DEPTH = 8;
    localparam int DEF_LEN_W = 8;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    typedef struct packed {
        logic                 level;
        logic [DEF_LEN_W-1:0] len;
    } seg_t;

endpackage

// File: rtl/wave_seg_table.sv
// rtl/wave_seg_table.sv - segment register file, synchronous write, combinational read
// Contents are never reset; entries are don't-care until written.
module wave_seg_table
    import wave_seq_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic                     wr_level,
    input  logic [LEN_W-1:0]         wr_len,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic                     rd_level,
    output logic [LEN_W-1:0]         rd_len
);

    logic             lvl_q [DEPTH];
    logic [LEN_W-1:0] len_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            lvl_q[wr_addr] <= wr_level;
            len_q[wr_addr] <= wr_len;
        end
    end

    assign rd_level = lvl_q[rd_addr];
    assign rd_len   = len_q[rd_addr];

endmodule

// File: rtl/wave_seq_gen.sv
// rtl/wave_seq_gen.sv - plays (level, duration) segments on one output bit
// Optional feature macro: WAVE_SEQ_LOOP_EN (adds loop_en, continuous replay).
module wave_seq_gen
    import wave_seq_pkg::*;
#(
    parameter int   DEPTH      = DEF_DEPTH,
    parameter int   LEN_W      = DEF_LEN_W,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cfg_we,
    input  logic [$clog2(DEPTH)-1:0] cfg_addr,
    input  logic                     cfg_level,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic [$clog2(DEPTH):0]   num_seg,
    input  logic                     start,
    input  logic                     abort,
`ifdef WAVE_SEQ_LOOP_EN
    input  logic                     loop_en,
`endif
    output logic                     wave_out,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH)-1:0] seg_idx
);

    localparam int AW = $clog2(DEPTH);
    localparam int NW = AW + 1;
    localparam logic [NW-1:0] DEPTH_N = NW'(DEPTH);

    state_t            state_q, state_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [NW-1:0]     n_q, n_d;
    logic              wave_q, wave_d;
    logic              done_q, done_d;
    logic              loop_q, loop_d;
    logic              loop_req;
    logic              last_seg;
    logic [AW-1:0]     rd_addr;
    logic              rd_level;
    logic [LEN_W-1:0]  rd_len;

`ifdef WAVE_SEQ_LOOP_EN
    assign loop_req = loop_en;
`else
    assign loop_req = 1'b0;
`endif

    // Writes are frozen while playing so the active list cannot change under us.
    wave_seg_table #(.DEPTH(DEPTH), .LEN_W(LEN_W)) u_table (
        .clk      (clk),
        .we       (cfg_we && (state_q == S_IDLE)),
        .wr_addr  (cfg_addr),
        .wr_level (cfg_level),
        .wr_len   (cfg_len),
        .rd_addr  (rd_addr),
        .rd_level (rd_level),
        .rd_len   (rd_len)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            n_q     <= '0;
            wave_q  <= IDLE_LEVEL;
            done_q  <= 1'b0;
            loop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            n_q     <= n_d;
            wave_q  <= wave_d;
            done_q  <= done_d;
            loop_q  <= loop_d;
        end
    end

    assign last_seg = (({1'b0, idx_q} + NW'(1)) >= n_q);

    // The read port always presents the segment that would be loaded next,
    // so a same-edge write to entry 0 is seen only after the start edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        n_d     = n_q;
        wave_d  = wave_q;
        done_d  = 1'b0;
        loop_d  = loop_q;
        rd_addr = '0;
        case (state_q)
            S_IDLE: begin
                wave_d = IDLE_LEVEL;
                idx_d  = '0;
                if (!abort && start) begin
                    if (num_seg == '0) begin
                        done_d = 1'b1;
                    end else begin
                        state_d = S_RUN;
                        n_d     = (num_seg > DEPTH_N) ? DEPTH_N : num_seg;
                        cnt_d   = rd_len;
                        wave_d  = rd_level;
                        loop_d  = loop_req;
                    end
                end
            end
            S_RUN: begin
                rd_addr = last_seg ? '0 : idx_q + AW'(1);
                if (abort) begin
                    state_d = S_IDLE;
                    wave_d  = IDLE_LEVEL;
                    idx_d   = '0;
                    cnt_d   = '0;
                end else if (cnt_q <= LEN_W'(1)) begin
                    // A zero length counts as one cycle, so <=1 marks the last cycle.
                    if (!last_seg || loop_q) begin
                        idx_d  = rd_addr;
                        cnt_d  = rd_len;
                        wave_d = rd_level;
                        done_d = last_seg;
                    end else begin
                        state_d = S_IDLE;
                        wave_d  = IDLE_LEVEL;
                        idx_d   = '0;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - LEN_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wave_out = wave_q;
    assign busy     = (state_q == S_RUN);
    assign done     = done_q;
    assign seg_idx  = idx_q;

endmodule
